// File: rtl/cpu_pkg.sv
// Shared types and constants for the five-stage MIPS-subset pipeline.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_MUL = 6'h18;

    localparam logic [XLEN-1:0] NOP = '0;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_MUL
    } alu_e;

    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        alu_e            alu_op;
        logic [RW-1:0]   rs;
        logic [RW-1:0]   rt;
        logic [RW-1:0]   dst;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [RW-1:0]   dst;
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] sdata;
    } ex_mem_t;

    typedef struct packed {
        logic            reg_write;
        logic [RW-1:0]   dst;
        logic [XLEN-1:0] res;
    } mem_wb_t;

    function automatic logic fwd_hit(
        input logic          rw,
        input logic [RW-1:0] dst,
        input logic [RW-1:0] src
    );
        return rw && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/cpu_if.sv
// Pipeline-state / forwarding bundle between the datapath and the
// hazard-forward unit.
interface cpu_if;
    logic [4:0]  idex_rs;
    logic [4:0]  idex_rt;
    logic [31:0] idex_a;
    logic [31:0] idex_b;
    logic        idex_mem_read;
    logic        exmem_rw;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_res;
    logic        memwb_rw;
    logic [4:0]  memwb_dst;
    logic [31:0] memwb_res;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        id_beq;
    logic        id_j;
    logic [31:0] id_da;
    logic [31:0] id_db;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic        hazard;
    logic        flush;

    modport master (
        output idex_rs, idex_rt, idex_a, idex_b, idex_mem_read,
        output exmem_rw, exmem_dst, exmem_res,
        output memwb_rw, memwb_dst, memwb_res,
        output ifid_rs, ifid_rt, id_beq, id_j, id_da, id_db,
        input  fwd_a, fwd_b, hazard, flush
    );

    modport slave (
        input  idex_rs, idex_rt, idex_a, idex_b, idex_mem_read,
        input  exmem_rw, exmem_dst, exmem_res,
        input  memwb_rw, memwb_dst, memwb_res,
        input  ifid_rs, ifid_rt, id_beq, id_j, id_da, id_db,
        output fwd_a, fwd_b, hazard, flush
    );
endinterface

// File: rtl/cpu_hazard.sv
// Forwarding muxes for EX operands, load-use stall detection and
// IF/ID flush generation for branches resolved in ID.
module hazard_forward_unit
    import cpu_pkg::*;
(
    cpu_if.slave hf
);
    always_comb begin
        hf.fwd_a = hf.idex_a;
        if (fwd_hit(hf.exmem_rw, hf.exmem_dst, hf.idex_rs))
            hf.fwd_a = hf.exmem_res;
        else if (fwd_hit(hf.memwb_rw, hf.memwb_dst, hf.idex_rs))
            hf.fwd_a = hf.memwb_res;
    end

    always_comb begin
        hf.fwd_b = hf.idex_b;
        if (fwd_hit(hf.exmem_rw, hf.exmem_dst, hf.idex_rt))
            hf.fwd_b = hf.exmem_res;
        else if (fwd_hit(hf.memwb_rw, hf.memwb_dst, hf.idex_rt))
            hf.fwd_b = hf.memwb_res;
    end

    assign hf.hazard = hf.idex_mem_read &&
                       (hf.idex_rt == hf.ifid_rs ||
                        hf.idex_rt == hf.ifid_rt);

    assign hf.flush = hf.id_j ||
                      (hf.id_beq && hf.id_da == hf.id_db);
endmodule

// File: rtl/cpu_units.sv
// Leaf blocks of the pipeline: PC, instruction memory, register file,
// byte-addressed data memory and ALU.
module cpu_pc (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_next,
    output logic [31:0] pc_o
);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     pc_o <= '0;
        else if (i_en) pc_o <= i_next;
    end
endmodule

module cpu_imem (
    input  logic [7:0]  i_idx,
    output logic [31:0] o_instr
);
    logic [31:0] memory [0:255];
    assign o_instr = memory[i_idx];
endmodule

module cpu_regfile (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_ra,
    input  logic [4:0]  i_rb,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_da,
    output logic [31:0] o_db
);
    logic [31:0] register [0:31];
    logic        w_wr;

    assign w_wr = i_we && (i_wa != 5'd0);

    always_ff @(posedge i_clk) begin
        if (w_wr) register[i_wa] <= i_wd;
    end

    // Same-cycle WB write is bypassed so ID sees it without an extra cycle.
    always_comb begin
        o_da = register[i_ra];
        o_db = register[i_rb];
        if (w_wr && i_wa == i_ra) o_da = i_wd;
        if (w_wr && i_wa == i_rb) o_db = i_wd;
        if (i_ra == 5'd0)         o_da = '0;
        if (i_rb == 5'd0)         o_db = '0;
    end
endmodule

module cpu_dmem (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd
);
    logic [7:0] mem [0:31];
    logic [4:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_addr;
    assign w_a1 = i_addr + 5'd1;
    assign w_a2 = i_addr + 5'd2;
    assign w_a3 = i_addr + 5'd3;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[w_a0] <= i_wd[7:0];
            mem[w_a1] <= i_wd[15:8];
            mem[w_a2] <= i_wd[23:16];
            mem[w_a3] <= i_wd[31:24];
        end
    end

    assign o_rd = {mem[w_a3], mem[w_a2], mem[w_a1], mem[w_a0]};
endmodule

module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_e        i_op,
    output logic [31:0] o_y
);
    always_comb begin
        o_y = '0;
        unique case (i_op)
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_MUL: o_y = i_a * i_b;
            default: o_y = '0;
        endcase
    end
endmodule

// File: rtl/cpu.sv
// Five-stage in-order MIPS-subset pipeline; pipeline registers live here,
// leaf blocks and the hazard-forward unit are instantiated below.
module cpu
    import cpu_pkg::*;
(
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);
    if_id_t  r_ifid;
    id_ex_t  r_idex, w_dec;
    ex_mem_t r_exmem, w_ex;
    mem_wb_t r_memwb, w_mem;

    logic        hazard, flush;
    logic        w_pc_en, w_beq, w_j;
    logic [31:0] w_pc, w_pc4, w_pc_next, w_instr;
    logic [31:0] w_imm, w_da, w_db, w_br_tgt, w_j_tgt;
    logic [31:0] w_alu_b, w_alu_y, w_rdata;
    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd;

    cpu_if hf ();

    // IF
    assign w_pc4     = w_pc + 32'd4;
    assign w_pc_en   = start_i & ~hazard;
    assign w_pc_next = flush ? (w_j ? w_j_tgt : w_br_tgt) : w_pc4;

    cpu_pc PC (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_en  (w_pc_en),
        .i_next(w_pc_next),
        .pc_o  (w_pc)
    );

    cpu_imem Instruction_Memory (
        .i_idx  (w_pc[9:2]),
        .o_instr(w_instr)
    );

    // ID
    assign w_op     = r_ifid.instr[31:26];
    assign w_rs     = r_ifid.instr[25:21];
    assign w_rt     = r_ifid.instr[20:16];
    assign w_rd     = r_ifid.instr[15:11];
    assign w_fn     = r_ifid.instr[5:0];
    assign w_imm    = {{16{r_ifid.instr[15]}}, r_ifid.instr[15:0]};
    assign w_br_tgt = r_ifid.pc4 + (w_imm << 2);
    assign w_j_tgt  = {r_ifid.pc4[31:28], r_ifid.instr[25:0], 2'b00};

    cpu_regfile Registers (
        .i_clk(clk_i),
        .i_we (r_memwb.reg_write),
        .i_ra (w_rs),
        .i_rb (w_rt),
        .i_wa (r_memwb.dst),
        .i_wd (r_memwb.res),
        .o_da (w_da),
        .o_db (w_db)
    );

    always_comb begin
        w_dec     = '0;
        w_dec.rs  = w_rs;
        w_dec.rt  = w_rt;
        w_dec.a   = w_da;
        w_dec.b   = w_db;
        w_dec.imm = w_imm;
        w_beq     = 1'b0;
        w_j       = 1'b0;
        unique case (w_op)
            OP_RTYPE: begin
                w_dec.dst = w_rd;
                unique case (w_fn)
                    FN_ADD: begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_ADD; end
                    FN_SUB: begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_SUB; end
                    FN_AND: begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_AND; end
                    FN_OR:  begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_OR;  end
                    FN_MUL: begin w_dec.reg_write = 1'b1; w_dec.alu_op = ALU_MUL; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.dst       = w_rt;
            end
            OP_LW: begin
                w_dec.reg_write = 1'b1;
                w_dec.mem_read  = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.dst       = w_rt;
            end
            OP_SW: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
            end
            OP_BEQ:  w_beq = 1'b1;
            OP_J:    w_j   = 1'b1;
            default: ;
        endcase
    end

    // EX
    assign w_alu_b = r_idex.alu_src ? r_idex.imm : hf.fwd_b;

    cpu_alu ALU (
        .i_a (hf.fwd_a),
        .i_b (w_alu_b),
        .i_op(r_idex.alu_op),
        .o_y (w_alu_y)
    );

    always_comb begin
        w_ex           = '0;
        w_ex.reg_write = r_idex.reg_write;
        w_ex.mem_read  = r_idex.mem_read;
        w_ex.mem_write = r_idex.mem_write;
        w_ex.dst       = r_idex.dst;
        w_ex.res       = w_alu_y;
        w_ex.sdata     = hf.fwd_b;
    end

    // MEM
    cpu_dmem Memory (
        .i_clk (clk_i),
        .i_we  (r_exmem.mem_write),
        .i_addr(r_exmem.res[4:0]),
        .i_wd  (r_exmem.sdata),
        .o_rd  (w_rdata)
    );

    always_comb begin
        w_mem           = '0;
        w_mem.reg_write = r_exmem.reg_write;
        w_mem.dst       = r_exmem.dst;
        w_mem.res       = r_exmem.mem_read ? w_rdata : r_exmem.res;
    end

    // Hazard / forwarding hookup
    assign hf.idex_rs       = r_idex.rs;
    assign hf.idex_rt       = r_idex.rt;
    assign hf.idex_a        = r_idex.a;
    assign hf.idex_b        = r_idex.b;
    assign hf.idex_mem_read = r_idex.mem_read;
    assign hf.exmem_rw      = r_exmem.reg_write;
    assign hf.exmem_dst     = r_exmem.dst;
    assign hf.exmem_res     = r_exmem.res;
    assign hf.memwb_rw      = r_memwb.reg_write;
    assign hf.memwb_dst     = r_memwb.dst;
    assign hf.memwb_res     = r_memwb.res;
    assign hf.ifid_rs       = w_rs;
    assign hf.ifid_rt       = w_rt;
    assign hf.id_beq        = w_beq;
    assign hf.id_j          = w_j;
    assign hf.id_da         = w_da;
    assign hf.id_db         = w_db;
    assign hazard           = hf.hazard;
    assign flush            = hf.flush;

    hazard_forward_unit HFU (.hf(hf));

    // A stall outranks a flush: IF/ID holds so the branch re-resolves.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ifid  <= '0;
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else begin
            if (!hazard) begin
                if (flush || !start_i) begin
                    r_ifid <= '0;
                end else begin
                    r_ifid.pc4   <= w_pc4;
                    r_ifid.instr <= w_instr;
                end
            end
            if (hazard) r_idex <= '0;
            else        r_idex <= w_dec;
            r_exmem <= w_ex;
            r_memwb <= w_mem;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed bench for the pipelined cpu: preloads memories through the
// fixed hierarchy and checks architectural state after each program.
module tb_cpu;
    logic clk_i   = 1'b0;
    logic rst_i   = 1'b1;
    logic start_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int bad, hz, fl, held, fl1;
    logic [31:0] prev, pcs;

    cpu dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(start_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rt(input logic [5:0] fn,
        input logic [4:0] rs, input logic [4:0] rtt, input logic [4:0] rd);
        return {6'h00, rs, rtt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rtt, input logic [15:0] imm);
        return {op, rs, rtt, imm};
    endfunction

    task automatic hold_reset();
        rst_i   = 1'b1;
        start_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            dut.Registers.register[i] = 32'h0;
            dut.Memory.mem[i] = 8'h00;
        end
    endtask

    task automatic go();
        rst_i   = 1'b0;
        start_i = 1'b1;
    endtask

    function automatic logic [31:0] rg(input int i);
        return dut.Registers.register[i];
    endfunction

    initial begin
        // reset state
        hold_reset();
        chk("rst_pc", dut.PC.pc_o, 32'h0);
        chk("rst_hazard", {31'h0, dut.hazard}, 32'h0);
        chk("rst_flush", {31'h0, dut.flush}, 32'h0);

        // 1: independent ALU ops
        dut.Registers.register[1] = 32'd5;
        dut.Registers.register[2] = 32'd3;
        dut.Instruction_Memory.memory[0]  = rt(6'h20, 1, 2, 3);
        dut.Instruction_Memory.memory[5]  = rt(6'h22, 1, 2, 4);
        dut.Instruction_Memory.memory[10] = rt(6'h24, 1, 2, 5);
        dut.Instruction_Memory.memory[15] = rt(6'h25, 1, 2, 6);
        dut.Instruction_Memory.memory[20] = rt(6'h18, 1, 2, 7);
        dut.Instruction_Memory.memory[25] = it(6'h08, 1, 8, 16'hFFF9);
        go();
        bad = 0;
        for (int j = 1; j <= 35; j++) begin
            @(negedge clk_i);
            if (dut.PC.pc_o !== 32'(4 * j) || dut.hazard || dut.flush) bad++;
        end
        chk("t1_pc_seq", 32'(bad), 32'd0);
        chk("t1_add", rg(3), 32'd8);
        chk("t1_sub", rg(4), 32'd2);
        chk("t1_and", rg(5), 32'd1);
        chk("t1_or", rg(6), 32'd7);
        chk("t1_mul", rg(7), 32'd15);
        chk("t1_addi", rg(8), 32'hFFFF_FFFE);

        // 2: back-to-back forwarding and EX/MEM priority
        hold_reset();
        dut.Instruction_Memory.memory[0] = it(6'h08, 0, 1, 16'd10);
        dut.Instruction_Memory.memory[1] = rt(6'h20, 1, 1, 2);
        dut.Instruction_Memory.memory[2] = rt(6'h22, 2, 1, 3);
        dut.Instruction_Memory.memory[3] = it(6'h08, 0, 6, 16'd1);
        dut.Instruction_Memory.memory[4] = it(6'h08, 0, 6, 16'd2);
        dut.Instruction_Memory.memory[5] = rt(6'h20, 6, 6, 7);
        go();
        hz = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk_i);
            if (dut.hazard) hz++;
        end
        chk("t2_r2", rg(2), 32'd20);
        chk("t2_r3", rg(3), 32'd10);
        chk("t2_prio", rg(7), 32'd4);
        chk("t2_nostall", 32'(hz), 32'd0);

        // 3: load-use
        hold_reset();
        dut.Memory.mem[4] = 8'h2A;
        dut.Instruction_Memory.memory[0] = it(6'h23, 0, 4, 16'd4);
        dut.Instruction_Memory.memory[1] = rt(6'h20, 4, 4, 5);
        go();
        hz = 0;
        held = 0;
        prev = dut.PC.pc_o;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk_i);
            if (dut.hazard) hz++;
            if (dut.PC.pc_o == prev) held++;
            prev = dut.PC.pc_o;
        end
        chk("t3_r4", rg(4), 32'd42);
        chk("t3_r5", rg(5), 32'd84);
        chk("t3_hazard_cnt", 32'(hz), 32'd1);
        chk("t3_pc_held", 32'(held), 32'd1);

        // 4: store then load back
        hold_reset();
        for (int i = 8; i < 12; i++) dut.Memory.mem[i] = 8'hFF;
        dut.Instruction_Memory.memory[0] = it(6'h08, 0, 1, 16'd99);
        dut.Instruction_Memory.memory[1] = it(6'h2B, 0, 1, 16'd8);
        dut.Instruction_Memory.memory[2] = it(6'h23, 0, 2, 16'd8);
        go();
        repeat (10) @(negedge clk_i);
        chk("t4_mem8", {24'h0, dut.Memory.mem[8]}, 32'h63);
        chk("t4_mem9_11", {8'h0, dut.Memory.mem[11],
            dut.Memory.mem[10], dut.Memory.mem[9]}, 32'h0);
        chk("t4_r2", rg(2), 32'd99);

        // 5: untaken beq at 0, taken beq at 0x10
        hold_reset();
        dut.Registers.register[12] = 32'd1;
        dut.Instruction_Memory.memory[0] = it(6'h04, 0, 12, 16'd5);
        dut.Instruction_Memory.memory[1] = it(6'h08, 0, 13, 16'd4);
        dut.Instruction_Memory.memory[4] = it(6'h04, 0, 0, 16'd2);
        dut.Instruction_Memory.memory[5] = it(6'h08, 0, 9, 16'd1);
        dut.Instruction_Memory.memory[6] = it(6'h08, 0, 10, 16'd2);
        dut.Instruction_Memory.memory[7] = it(6'h08, 0, 11, 16'd3);
        go();
        fl = 0;
        fl1 = 0;
        pcs = 32'h0;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk_i);
            if (dut.flush) fl++;
            if (j == 1) fl1 = int'(dut.flush);
            if (j == 6) pcs = dut.PC.pc_o;
        end
        chk("t5_untaken", 32'(fl1), 32'd0);
        chk("t5_flush_cnt", 32'(fl), 32'd1);
        chk("t5_pc_tgt", pcs, 32'h1C);
        chk("t5_r9_squash", rg(9), 32'd0);
        chk("t5_r10_skip", rg(10), 32'd0);
        chk("t5_r11", rg(11), 32'd3);
        chk("t5_r13", rg(13), 32'd4);

        // 6a: jump
        hold_reset();
        dut.Instruction_Memory.memory[0]  = {6'h02, 26'h10};
        dut.Instruction_Memory.memory[1]  = it(6'h08, 0, 14, 16'd5);
        dut.Instruction_Memory.memory[16] = it(6'h08, 0, 15, 16'd6);
        go();
        fl = 0;
        pcs = 32'h0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk_i);
            if (dut.flush) fl++;
            if (j == 2) pcs = dut.PC.pc_o;
        end
        chk("t6_pc_jump", pcs, 32'h40);
        chk("t6_flush_cnt", 32'(fl), 32'd1);
        chk("t6_r14_squash", rg(14), 32'd0);
        chk("t6_r15", rg(15), 32'd6);

        // 6b: reset mid-run kills in-flight writes
        hold_reset();
        for (int i = 0; i < 5; i++)
            dut.Instruction_Memory.memory[i] = it(6'h08, 0, 5'(16 + i), 16'(i + 1));
        go();
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("t6_rst_pc", dut.PC.pc_o, 32'h0);
        repeat (6) @(negedge clk_i);
        chk("t6_rst_nowb", rg(16) | rg(17) | rg(18) | rg(19) | rg(20), 32'h0);

        // 6c: start_i low freezes the PC
        rst_i = 1'b0;
        start_i = 1'b1;
        repeat (3) @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("t6_start_hold", dut.PC.pc_o, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
